// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED mode scheduler: mode encoding, duty constants
// and chase-position helpers.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_BLINK   = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_CHASE   = 2'd3
    } mode_e;

    localparam int NUM_LEDS = 6;
    localparam int DUTY_W   = 10;

    localparam logic [DUTY_W-1:0] DUTY_FULL = 10'd1023;
    localparam logic [DUTY_W-1:0] DUTY_TAIL = 10'd256;

    typedef logic [NUM_LEDS-1:0][DUTY_W-1:0] duty_vec_t;

    function automatic logic [2:0] pos_next(input logic [2:0] pos);
        return (pos == 3'd5) ? 3'd0 : pos + 3'd1;
    endfunction

    function automatic logic [2:0] pos_prev(input logic [2:0] pos);
        return (pos == 3'd0) ? 3'd5 : pos - 3'd1;
    endfunction

endpackage

// File: rtl/led_mode_scheduler_if.sv
// Board-side signal bundle of the scheduler: raw keys in, LEDs and mode out.
interface led_mode_scheduler_if;
    import led_ctrl_pkg::*;

    logic [1:0]          key;
    logic [NUM_LEDS-1:0] led;
    logic [1:0]          mode;

    modport master (output key, input led, input mode);
    modport slave  (input key, output led, output mode);
endinterface

// File: rtl/led_mode_scheduler_key_debounce.sv
// One pushbutton: 2-flop synchronizer, tick-based debounce and a 1-cycle
// press pulse on the debounced 1->0 edge.
module key_debounce #(
    parameter int DEBOUNCE_TICKS = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic key_raw,
    output logic press
);
    localparam int CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic [1:0]       sync_q, sync_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d  = {sync_q[0], key_raw};
        level_d = level_q;
        cnt_d   = cnt_q;
        if (tick) begin
            if (sync_q[1] == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Pulse fires in the same edge that the debounced level falls.
        press_d = level_q & ~level_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/led_mode_scheduler.sv
// Key-driven LED mode scheduler: OFF / BLINK / BREATHE / CHASE patterns
// rendered through a shared 10-bit PWM onto six active-low LEDs.
module led_mode_scheduler
    import led_ctrl_pkg::*;
#(
    parameter int TICK_DIV       = 270_000,
    parameter int DEBOUNCE_TICKS = 2,
    parameter int BLINK_TICKS    = 50,
    parameter int CHASE_TICKS    = 10,
    parameter int STEP           = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          key,
    output logic [NUM_LEDS-1:0] led,
    output logic [1:0]          mode
);
    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SUB_MAX = (BLINK_TICKS > CHASE_TICKS) ? BLINK_TICKS : CHASE_TICKS;
    localparam int SUB_W   = (SUB_MAX > 1) ? $clog2(SUB_MAX + 1) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [SUB_W-1:0]  BLINK_LAST = SUB_W'(BLINK_TICKS - 1);
    localparam logic [SUB_W-1:0]  CHASE_LAST = SUB_W'(CHASE_TICKS - 1);
    localparam logic [DUTY_W-1:0] STEP_V     = DUTY_W'(STEP);
    localparam logic [DUTY_W-1:0] UP_LIM     = DUTY_FULL - STEP_V;

    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic                tick;
    mode_e               mode_q, mode_d;
    logic [SUB_W-1:0]    sub_q, sub_d;
    logic                phase_q, phase_d;
    logic [DUTY_W-1:0]   bright_q, bright_d;
    logic                dir_down_q, dir_down_d;
    logic [2:0]          pos_q, pos_d;
    logic [DUTY_W-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    duty_vec_t           duty;
    logic                next_press, prev_press;

    assign tick = (tick_cnt_q == TICK_LAST);

    key_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_key_next (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .key_raw (key[0]),
        .press   (next_press)
    );

    key_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_key_prev (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .key_raw (key[1]),
        .press   (prev_press)
    );

    always_comb begin
        mode_d = mode_q;
        if (next_press && prev_press) begin
            mode_d = MODE_OFF;
        end else if (next_press) begin
            mode_d = mode_e'(mode_q + 2'd1);
        end else if (prev_press) begin
            mode_d = mode_e'(mode_q - 2'd1);
        end
    end

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        pwm_cnt_d  = pwm_cnt_q + 1'b1;
        sub_d      = sub_q;
        phase_d    = phase_q;
        bright_d   = bright_q;
        dir_down_d = dir_down_q;
        pos_d      = pos_q;
        // A mode change restarts every pattern from its origin in the same edge.
        if (mode_d != mode_q) begin
            sub_d      = '0;
            phase_d    = 1'b0;
            bright_d   = '0;
            dir_down_d = 1'b0;
            pos_d      = '0;
        end else if (tick) begin
            case (mode_q)
                MODE_BLINK: begin
                    if (sub_q == BLINK_LAST) begin
                        sub_d   = '0;
                        phase_d = ~phase_q;
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
                MODE_BREATHE: begin
                    if (!dir_down_q) begin
                        if (bright_q >= UP_LIM) begin
                            bright_d   = DUTY_FULL;
                            dir_down_d = 1'b1;
                        end else begin
                            bright_d = bright_q + STEP_V;
                        end
                    end else begin
                        if (bright_q <= STEP_V) begin
                            bright_d   = '0;
                            dir_down_d = 1'b0;
                        end else begin
                            bright_d = bright_q - STEP_V;
                        end
                    end
                end
                MODE_CHASE: begin
                    if (sub_q == CHASE_LAST) begin
                        sub_d = '0;
                        pos_d = pos_next(pos_q);
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        duty = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (mode_q)
                MODE_BLINK:   duty[i] = ((i % 2 == 0) == phase_q) ? DUTY_FULL : '0;
                MODE_BREATHE: duty[i] = bright_q;
                MODE_CHASE: begin
                    if (3'(i) == pos_q) begin
                        duty[i] = DUTY_FULL;
                    end else if (3'(i) == pos_prev(pos_q)) begin
                        duty[i] = DUTY_TAIL;
                    end
                end
                default: duty[i] = '0;
            endcase
        end
    end

    always_comb begin
        led_d = '1;
        for (int i = 0; i < NUM_LEDS; i++) begin
            led_d[i] = ~(pwm_cnt_q < duty[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            mode_q     <= MODE_OFF;
            sub_q      <= '0;
            phase_q    <= 1'b0;
            bright_q   <= '0;
            dir_down_q <= 1'b0;
            pos_q      <= '0;
            pwm_cnt_q  <= '0;
            led_q      <= '1;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            mode_q     <= mode_d;
            sub_q      <= sub_d;
            phase_q    <= phase_d;
            bright_q   <= bright_d;
            dir_down_q <= dir_down_d;
            pos_q      <= pos_d;
            pwm_cnt_q  <= pwm_cnt_d;
            led_q      <= led_d;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;

endmodule
